// File: rtl/interrupt_priority_controller_if.sv
// ---------------------------------------------------------------------------
// interrupt_priority_controller_if
// Bundles the interrupt request, mask, CPU handshake and status signals of
// the interrupt priority controller.
//   irq_in   [5:0] : interrupt request lines (bit 5 highest priority)
//   mask_in  [5:0] : new mask value, 1 = line disabled
//   ld_mask        : one-cycle strobe, loads mask_in
//   inta           : CPU acknowledge, level
//   eoi            : one-cycle end-of-interrupt strobe
//   intr           : interrupt request to CPU
//   intr_num [2:0] : encoded interrupt number
//   isr      [5:0] : in-service register
//   irr      [5:0] : interrupt request (pending) register
// master = CPU / IO side driving requests, slave = the controller.
// ---------------------------------------------------------------------------
interface interrupt_priority_controller_if;
    logic [5:0] irq_in;
    logic [5:0] mask_in;
    logic       ld_mask;
    logic       inta;
    logic       eoi;
    logic       intr;
    logic [2:0] intr_num;
    logic [5:0] isr;
    logic [5:0] irr;

    modport master (
        output irq_in, mask_in, ld_mask, inta, eoi,
        input  intr, intr_num, isr, irr
    );

    modport slave (
        input  irq_in, mask_in, ld_mask, inta, eoi,
        output intr, intr_num, isr, irr
    );
endinterface

// File: rtl/interrupt_priority_controller.sv
// ---------------------------------------------------------------------------
// interrupt_priority_controller
// Six-line prioritised interrupt controller with nesting. Requests are
// synchronised, edge detected and latched into irr; the highest unmasked
// pending line that outranks everything in service is presented to the CPU
// on intr/intr_num, moved into isr on acknowledge and retired by eoi.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : controller side of interrupt_priority_controller_if
// ---------------------------------------------------------------------------
module interrupt_priority_controller (
    input  logic                                  clk,
    input  logic                                  reset,
    interrupt_priority_controller_if.slave        bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_ACKW} state_t;

    state_t     r_state;
    logic [5:0] r_sync1;
    logic [5:0] r_sync2;
    logic [5:0] r_sync3;
    logic [1:0] r_warm;
    logic [5:0] r_irr;
    logic [5:0] r_isr;
    logic [5:0] r_mask;
    logic       r_intr;
    logic [2:0] r_intr_num;
    logic [2:0] r_line;

    logic [5:0] w_edge;
    logic [5:0] w_allow;
    logic [5:0] w_isr_top;
    logic [5:0] w_pend;
    logic       w_cand_valid;
    logic [2:0] w_cand_idx;
    logic       w_ack;
    logic [5:0] w_ack_bit;
    logic [5:0] w_eoi_clr;

    // Edge detection is held off until the synchroniser has been refilled
    // with real samples after reset, so lines already high at release do
    // not look like fresh rising edges.
    always_comb begin
        w_edge    = (r_warm == 2'd3) ? (r_sync2 & ~r_sync3) : '0;
        w_allow   = '0;
        w_isr_top = '0;
        for (int unsigned k = 0; k < 6; k++) begin
            // line k may interrupt only if nothing at or above k is in service
            w_allow[k] = ((r_isr >> k) == 6'd0);
            if (r_isr[k]) begin
                w_isr_top = 6'b000001 << k;
            end
        end
    end

    always_comb begin
        w_pend       = r_irr & ~r_mask & w_allow;
        w_cand_valid = |w_pend;
        w_cand_idx   = '0;
        for (int unsigned k = 0; k < 6; k++) begin
            if (w_pend[k]) begin
                w_cand_idx = 3'(k);
            end
        end
        w_ack     = (r_state == ST_REQ) && bus.inta;
        w_ack_bit = w_ack ? (6'b000001 << r_line) : '0;
        w_eoi_clr = bus.eoi ? w_isr_top : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
            r_warm  <= '0;
            r_irr   <= '0;
            r_isr   <= '0;
            r_mask  <= '0;
        end else begin
            r_sync1 <= bus.irq_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            if (r_warm != 2'd3) begin
                r_warm <= r_warm + 2'd1;
            end
            // acknowledge clear wins over a coincident edge on the same line
            r_irr <= (r_irr | w_edge) & ~w_ack_bit;
            // eoi retires the pre-existing top bit; the acked bit joins in the same edge
            r_isr <= (r_isr & ~w_eoi_clr) | w_ack_bit;
            if (bus.ld_mask) begin
                r_mask <= bus.mask_in;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_intr     <= 1'b0;
            r_intr_num <= 3'd0;
            r_line     <= 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cand_valid) begin
                        r_state    <= ST_REQ;
                        r_intr     <= 1'b1;
                        r_intr_num <= 3'd6 - w_cand_idx;
                        r_line     <= w_cand_idx;
                    end else begin
                        r_intr <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (bus.inta) begin
                        r_intr  <= 1'b0;
                        r_state <= ST_ACKW;
                    end
                end
                ST_ACKW: begin
                    if (!bus.inta) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_intr  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.intr     = r_intr;
    assign bus.intr_num = r_intr_num;
    assign bus.isr      = r_isr;
    assign bus.irr      = r_irr;

endmodule

// File: doc/interrupt_priority_controller.md
INTERRUPT_PRIORITY_CONTROLLER -- requirements
Module: interrupt_priority_controller

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; forces all state to reset values immediately while low.
REQ-003 irq_in  input  6  interrupt request lines from IO modules; irq_in[5] highest priority, irq_in[0] lowest; asynchronous to clk.
REQ-004 mask_in  input  6  new interrupt mask value; 1 = line disabled.
REQ-005 ld_mask  input  1  one-cycle strobe; loads mask_in into mask register.
REQ-006 inta  input  1  CPU interrupt acknowledge, level, held high until intr seen low.
REQ-007 eoi  input  1  one-cycle end-of-interrupt strobe from CPU.
REQ-008 intr  output  1  interrupt request to CPU, registered.
REQ-009 intr_num  output  3  encoded interrupt number; drives the next-ISR decoder's 3-bit request input.
REQ-010 isr  output  6  in-service register; drives the next-ISR decoder's 6-bit in-service input; bit k set while line k is being serviced.
REQ-011 irr  output  6  interrupt request register (pending, latched), for status reads.

Function
REQ-012 Each irq_in bit SHALL pass a 2-flop synchronizer, then a rising-edge detector (sync output high, previous sync sample low).
REQ-013 irr[k] SHALL set on the clock edge where the edge detector for line k fires; latency from irq_in[k] high at edge N is irr[k]=1 after edge N+2.
REQ-014 irr[k] SHALL clear only on acknowledge of line k (REQ-019); a new edge on an already pending line is absorbed.
REQ-015 Mask SHALL gate selection only; masked lines still latch into irr and remain pending until unmasked.
REQ-016 Candidate = highest set bit of (irr & ~mask) that is strictly higher priority than the highest set isr bit (any bit if isr == 0); nested service of higher-priority lines permitted.
REQ-017 Encoding: line 5->3'd1, 4->3'd2, 3->3'd3, 2->3'd4, 1->3'd5, 0->3'd6; 3'd0 and 3'd7 never produced except 3'd0 at reset.
REQ-018 FSM states IDLE, REQ, ACKW. IDLE: if candidate exists -> REQ next edge, intr<=1, intr_num<=encoding of candidate. Otherwise stay, intr=0.
REQ-019 REQ: intr=1, intr_num frozen even if higher-priority request arrives. On inta=1: isr[k]<=1, irr[k]<=0 for k = frozen line, intr<=0, -> ACKW.
REQ-020 ACKW: stay while inta=1; on inta=0 -> IDLE. intr_num holds last acknowledged number until the next REQ entry.
REQ-021 eoi (any state) SHALL clear the highest-priority isr bit set before that edge; eoi with isr==0 is ignored.
REQ-022 eoi coincident with inta acknowledge: eoi clears the highest pre-existing isr bit, the acknowledged bit is set; both effects in the same edge.
REQ-023 ld_mask in REQ state SHALL NOT withdraw intr; the frozen request completes normally.
REQ-024 Minimum latency IDLE candidate -> intr high = 1 clock.

Reset
REQ-025 While reset low: intr=0, intr_num=3'd0, isr=0, irr=0, mask=6'b000000, synchronizer/edge flops=0, state=IDLE.
REQ-026 Reset release mid-REQ or mid-ACKW SHALL leave the block in IDLE with no pending or in-service bits; irq_in lines already high at release produce no edge (sync flops fill to 1 without a 0->1 edge until the third edge) — lines high at release SHALL be recognised only after going low and high again.

Verification
REQ-027 irq_in=6'b000100 pulse from reset state -> irr=6'b000100 after 3 edges, intr=1 next edge, intr_num=3'd4; inta -> isr=6'b000100, irr=0, intr=0.
REQ-028 irq_in[1] and irq_in[4] rise same cycle -> intr_num=3'd2 first; after ack and eoi, intr_num=3'd5, isr sequence 010000 -> 000000 -> 000010.
REQ-029 Nesting: isr=6'b000100 in service, irq_in[5] rises -> intr=1, intr_num=3'd1; ack -> isr=6'b100100; eoi -> isr=6'b000100.
REQ-030 Lower priority while serving: isr=6'b010000, irq_in[0] rises -> irr[0]=1, intr stays 0 until eoi, then intr=1, intr_num=3'd6.
REQ-031 Mask: ld_mask with mask_in=6'b001000, irq_in[3] rises -> irr[3]=1, intr=0; load mask 0 -> intr=1, intr_num=3'd3.
REQ-032 Reset asserted in REQ with irr=6'b000011 -> all outputs 0 immediately, state IDLE after release.
